// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the multi-digit decade counter:
//   BCD_DIGIT_W  width of one BCD digit
//   BCD_MAX      largest legal BCD digit value (9)
//   bcd_digit_t  one BCD digit
//   bcd_clamp()  limits a digit to a given maximum
// ----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit,
                                            input bcd_digit_t max);
      return (digit > max) ? max : digit;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One decade stage of the BCD counter. Loads a clamped value, increments or
// decrements with wrap at its own maximum, and flags its limits.
// Ports:
//   i_clk      clock, rising edge
//   i_sclr     synchronous active-high clear (wins over everything)
//   i_load     parallel load strobe (wins over inc/dec)
//   i_din      digit load value, clamped to i_max
//   i_inc      step this digit up
//   i_dec      step this digit down
//   i_max      largest legal value of this digit
//   o_digit    registered digit value
//   o_at_max   digit equals i_max
//   o_at_zero  digit equals zero
// ----------------------------------------------------------------------------
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_sclr,
   input  logic       i_load,
   input  bcd_digit_t i_din,
   input  logic       i_inc,
   input  logic       i_dec,
   input  bcd_digit_t i_max,
   output bcd_digit_t o_digit,
   output logic       o_at_max,
   output logic       o_at_zero
);

   bcd_digit_t digit_q;
   bcd_digit_t digit_d;

   assign o_at_max  = (digit_q == i_max);
   assign o_at_zero = (digit_q == '0);
   assign o_digit   = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (i_load) begin
         digit_d = bcd_clamp(i_din, i_max);
      end else if (i_inc) begin
         digit_d = o_at_max ? '0 : digit_q + 4'd1;
      end else if (i_dec) begin
         digit_d = o_at_zero ? i_max : digit_q - 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_sclr) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// ----------------------------------------------------------------------------
// bcd_counter_multi
// Parametrised multi-digit BCD up/down counter with parallel load and a
// configurable modulus on the most significant digit.
// Build option: define BCD_COUNTER_SATURATE_EN to stop at max (up) / 0 (down)
// instead of wrapping; o_cout/o_bout then never assert.
// Parameters:
//   DIGITS   number of BCD digits (1..8)
//   TOP_MOD  modulus of the most significant digit (2..10)
// Ports:
//   i_clk       clock, rising edge
//   i_sclr      synchronous active-high clear
//   i_cin       count enable
//   i_up        direction, 1 = up, 0 = down
//   i_load      parallel load strobe
//   i_din       BCD load value, digit 0 in [3:0]
//   o_cnt       registered BCD count
//   o_cout      one-cycle pulse after an up-wrap (max -> 0)
//   o_bout      one-cycle pulse after a down-wrap (0 -> max)
//   o_tc        terminal count for the current direction (combinational)
//   o_load_err  one-cycle pulse after a load that needed clamping
// ----------------------------------------------------------------------------
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int TOP_MOD = 10
) (
   input  logic                  i_clk,
   input  logic                  i_sclr,
   input  logic                  i_cin,
   input  logic                  i_up,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_din,
   output logic [4*DIGITS-1:0]   o_cnt,
   output logic                  o_cout,
   output logic                  o_bout,
   output logic                  o_tc,
   output logic                  o_load_err
);

   localparam bcd_digit_t TOP_MAX = bcd_digit_t'(TOP_MOD - 1);

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_zero;
   logic [DIGITS-1:0] clamp_hit;
   logic [DIGITS:0]   chain_max;
   logic [DIGITS:0]   chain_zero;
   logic              all_max;
   logic              all_zero;
   logic              hold_up;
   logic              hold_dn;
   logic              step_up;
   logic              step_dn;

   logic cout_q, cout_d;
   logic bout_q, bout_d;
   logic load_err_q, load_err_d;

   // chain_*[k] is high when every digit below k sits at its limit, i.e. the
   // ripple enable for digit k; chain_*[DIGITS] covers the whole count.
   always_comb begin
      logic acc_max;
      logic acc_zero;
      acc_max    = 1'b1;
      acc_zero   = 1'b1;
      chain_max  = '0;
      chain_zero = '0;
      for (int k = 0; k <= DIGITS; k++) begin
         chain_max[k]  = acc_max;
         chain_zero[k] = acc_zero;
         if (k < DIGITS) begin
            acc_max  = acc_max & at_max[k];
            acc_zero = acc_zero & at_zero[k];
         end
      end
   end

   assign all_max  = chain_max[DIGITS];
   assign all_zero = chain_zero[DIGITS];

`ifdef BCD_COUNTER_SATURATE_EN
   // Blocking the step at the limit also keeps the wrap pulses low.
   assign hold_up = all_max;
   assign hold_dn = all_zero;
`else
   assign hold_up = 1'b0;
   assign hold_dn = 1'b0;
`endif

   assign step_up = i_cin & i_up  & ~i_load & ~hold_up;
   assign step_dn = i_cin & ~i_up & ~i_load & ~hold_dn;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      localparam bcd_digit_t DIG_MAX = (k == DIGITS - 1) ? TOP_MAX : BCD_MAX;

      assign clamp_hit[k] = (i_din[4*k +: 4] > DIG_MAX);

      bcd_digit u_digit (
         .i_clk     (i_clk),
         .i_sclr    (i_sclr),
         .i_load    (i_load),
         .i_din     (i_din[4*k +: 4]),
         .i_inc     (step_up & chain_max[k]),
         .i_dec     (step_dn & chain_zero[k]),
         .i_max     (DIG_MAX),
         .o_digit   (o_cnt[4*k +: 4]),
         .o_at_max  (at_max[k]),
         .o_at_zero (at_zero[k])
      );
   end

   assign cout_d     = step_up & all_max;
   assign bout_d     = step_dn & all_zero;
   assign load_err_d = i_load & (|clamp_hit);

   always_ff @(posedge i_clk) begin
      if (i_sclr) begin
         cout_q     <= 1'b0;
         bout_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         cout_q     <= cout_d;
         bout_q     <= bout_d;
         load_err_q <= load_err_d;
      end
   end

   assign o_cout     = cout_q;
   assign o_bout     = bout_q;
   assign o_load_err = load_err_q;
   assign o_tc       = i_up ? all_max : all_zero;

endmodule

// File: tb/tb_bcd_counter_multi.sv
module tb_bcd_counter_multi;

   logic       clk = 1'b0;
   logic       sclr = 1'b0;
   logic       cin = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [7:0] din = '0;

   logic [7:0] cnt_a, cnt_b;
   logic       cout_a, bout_a, tc_a, err_a;
   logic       cout_b, bout_b, tc_b, err_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state per instance: 0 = TOP_MOD 10, 1 = TOP_MOD 6
   int m_val  [2];
   bit m_cout [2];
   bit m_bout [2];
   bit m_err  [2];
   int m_tmod [2] = '{10, 6};

   always #5 clk = ~clk;

   bcd_counter_multi #(.DIGITS(2), .TOP_MOD(10)) dut_a (
      .i_clk(clk), .i_sclr(sclr), .i_cin(cin), .i_up(up), .i_load(load),
      .i_din(din), .o_cnt(cnt_a), .o_cout(cout_a), .o_bout(bout_a),
      .o_tc(tc_a), .o_load_err(err_a)
   );

   bcd_counter_multi #(.DIGITS(2), .TOP_MOD(6)) dut_b (
      .i_clk(clk), .i_sclr(sclr), .i_cin(cin), .i_up(up), .i_load(load),
      .i_din(din), .o_cnt(cnt_b), .o_cout(cout_b), .o_bout(bout_b),
      .o_tc(tc_b), .o_load_err(err_b)
   );

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   // Behavioural model: the count is a plain integer 0..max.
   task automatic model_step(input int i);
      int maxv, d0, d1;
      maxv = m_tmod[i] * 10 - 1;
      m_cout[i] = 0;
      m_bout[i] = 0;
      m_err[i]  = 0;
      if (sclr) begin
         m_val[i] = 0;
      end else if (load) begin
         d0 = int'(din[3:0]);
         d1 = int'(din[7:4]);
         if (d0 > 9)              begin d0 = 9;             m_err[i] = 1; end
         if (d1 > m_tmod[i] - 1)  begin d1 = m_tmod[i] - 1; m_err[i] = 1; end
         m_val[i] = d1 * 10 + d0;
      end else if (cin) begin
         if (up) begin
            if (m_val[i] == maxv) begin
`ifndef BCD_COUNTER_SATURATE_EN
               m_val[i]  = 0;
               m_cout[i] = 1;
`endif
            end else begin
               m_val[i] = m_val[i] + 1;
            end
         end else begin
            if (m_val[i] == 0) begin
`ifndef BCD_COUNTER_SATURATE_EN
               m_val[i]  = maxv;
               m_bout[i] = 1;
`endif
            end else begin
               m_val[i] = m_val[i] - 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all();
      logic exp_tc_a, exp_tc_b;
      exp_tc_a = up ? (m_val[0] == 99) : (m_val[0] == 0);
      exp_tc_b = up ? (m_val[1] == 59) : (m_val[1] == 0);
      chk("cnt_a",  cnt_a,        to_bcd(m_val[0]));
      chk("cout_a", {7'd0, cout_a}, {7'd0, m_cout[0]});
      chk("bout_a", {7'd0, bout_a}, {7'd0, m_bout[0]});
      chk("err_a",  {7'd0, err_a},  {7'd0, m_err[0]});
      chk("tc_a",   {7'd0, tc_a},   {7'd0, exp_tc_a});
      chk("cnt_b",  cnt_b,        to_bcd(m_val[1]));
      chk("cout_b", {7'd0, cout_b}, {7'd0, m_cout[1]});
      chk("bout_b", {7'd0, bout_b}, {7'd0, m_bout[1]});
      chk("err_b",  {7'd0, err_b},  {7'd0, m_err[1]});
      chk("tc_b",   {7'd0, tc_b},   {7'd0, exp_tc_b});
   endtask

   task automatic cyc(input logic s, input logic l, input logic c,
                      input logic u, input logic [7:0] d);
      sclr = s; load = l; cin = c; up = u; din = d;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   initial begin
      // Random count, then a clear
      cyc(1, 0, 0, 1, 8'h00);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1'($urandom_range(0, 1)), 8'h00);
      cyc(1, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);

      // Up from 98 through the wrap (instance b clamps to 58)
      cyc(0, 1, 0, 1, 8'h98);
      cyc(0, 0, 1, 1, 8'h00);
      cyc(0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);

      // Down from 00 through the wrap, then one more step
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 8'h00);
      cyc(0, 0, 1, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);

      // Clamped load, load while counting, load with clear
      cyc(0, 1, 0, 1, 8'h7A);
      cyc(0, 1, 1, 1, 8'h42);
      cyc(1, 1, 1, 1, 8'h55);

      // Enable toggled 1,0,1 from 09
      cyc(0, 1, 0, 1, 8'h09);
      cyc(0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);
      cyc(0, 0, 1, 1, 8'h00);

      // Sitting at max with continuous up count
      cyc(0, 1, 0, 1, 8'h99);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h00);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
